// File: rtl/unified_mem_arbiter.sv
// Single-ported unified memory arbiter between instruction fetch and the MEM stage.
// Strict MEM-first priority, fixed-latency accesses, one-cycle ready pulses.
module unified_mem_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  resetN,
    // instruction fetch side
    input  logic                  ifReq,
    input  logic [ADDR_WIDTH-1:0] ifAddr,
    input  logic                  flushIF,
    output logic [DATA_WIDTH-1:0] ifData,
    output logic                  ifReady,
    // load/store side
    input  logic                  memReadMEM,
    input  logic                  memWriteMEM,
    input  logic [ADDR_WIDTH-1:0] memAddrMEM,
    input  logic [DATA_WIDTH-1:0] memWDataMEM,
    output logic [DATA_WIDTH-1:0] memRData,
    output logic                  memReady,
    // memory port
    output logic                  ramEn,
    output logic                  ramWe,
    output logic [ADDR_WIDTH-1:0] ramAddr,
    output logic [DATA_WIDTH-1:0] ramWData,
    input  logic [DATA_WIDTH-1:0] ramRData,
    // pipeline freeze
    output logic                  stallIF,
    output logic                  stallPipe
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_ACC  = 2'd1,
        MEM_ACC = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t                stateReg,    stateNext;
    logic [3:0]            cntReg,      cntNext;
    logic                  staleReg,    staleNext;
    logic [ADDR_WIDTH-1:0] addrReg,     addrNext;
    logic                  weReg,       weNext;
    logic [DATA_WIDTH-1:0] wdataReg,    wdataNext;
    logic [DATA_WIDTH-1:0] ifDataReg,   ifDataNext;
    logic [DATA_WIDTH-1:0] memRDataReg, memRDataNext;
    logic                  ifReadyReg,  ifReadyNext;
    logic                  memReadyReg, memReadyNext;

    logic memReq;
    logic lastCycle;
    logic fetchStale;

    assign memReq     = memReadMEM | memWriteMEM;
    assign lastCycle  = (cntReg == 4'd0);
    // A flush arriving in the completion cycle itself must still suppress the result.
    assign fetchStale = staleReg | flushIF;

    // State and datapath registers
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            stateReg    <= IDLE;
            cntReg      <= 4'd0;
            staleReg    <= 1'b0;
            addrReg     <= '0;
            weReg       <= 1'b0;
            wdataReg    <= '0;
            ifDataReg   <= '0;
            memRDataReg <= '0;
            ifReadyReg  <= 1'b0;
            memReadyReg <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            cntReg      <= cntNext;
            staleReg    <= staleNext;
            addrReg     <= addrNext;
            weReg       <= weNext;
            wdataReg    <= wdataNext;
            ifDataReg   <= ifDataNext;
            memRDataReg <= memRDataNext;
            ifReadyReg  <= ifReadyNext;
            memReadyReg <= memReadyNext;
        end
    end

    // Next-state and datapath update
    always_comb begin
        stateNext    = stateReg;
        cntNext      = cntReg;
        staleNext    = staleReg;
        addrNext     = addrReg;
        weNext       = weReg;
        wdataNext    = wdataReg;
        ifDataNext   = ifDataReg;
        memRDataNext = memRDataReg;
        ifReadyNext  = 1'b0;
        memReadyNext = 1'b0;

        unique case (stateReg)
            IDLE: begin
                if (memReq) begin
                    stateNext = MEM_ACC;
                    addrNext  = memAddrMEM;
                    weNext    = memWriteMEM;
                    wdataNext = memWDataMEM;
                    cntNext   = CNT_INIT;
                end else if (ifReq) begin
                    stateNext = IF_ACC;
                    addrNext  = ifAddr;
                    weNext    = 1'b0;
                    cntNext   = CNT_INIT;
                    staleNext = 1'b0;
                end
            end
            IF_ACC: begin
                staleNext = fetchStale;
                if (!lastCycle) begin
                    cntNext = cntReg - 4'd1;
                end else begin
                    stateNext = IDLE;
                    if (!fetchStale) begin
                        ifDataNext  = ramRData;
                        ifReadyNext = 1'b1;
                    end
                end
            end
            MEM_ACC: begin
                if (!lastCycle) begin
                    cntNext = cntReg - 4'd1;
                end else begin
                    stateNext    = IDLE;
                    memReadyNext = 1'b1;
                    if (!weReg) begin
                        memRDataNext = ramRData;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Outputs; the port is driven only from latched registers so it stays stable mid-access
    always_comb begin
        ramEn     = (stateReg != IDLE);
        ramWe     = (stateReg == MEM_ACC) & weReg;
        ramAddr   = addrReg;
        ramWData  = wdataReg;
        ifData    = ifDataReg;
        memRData  = memRDataReg;
        ifReady   = ifReadyReg;
        memReady  = memReadyReg;
        stallPipe = memReq & ~memReadyReg;
        stallIF   = ifReq & ~ifReadyReg;
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: instance 0 runs MEM_LATENCY=2, instance 1 runs 1.
// Stimulus pushes expected ready events and port accesses; a negedge monitor pops and compares.
module tb_unified_mem_arbiter;

    logic        clock = 1'b0;
    logic        resetN;
    logic        ifReq, flushIF, memReadMEM, memWriteMEM;
    logic [31:0] ifAddr, memAddrMEM, memWDataMEM;
    logic        sel;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rdy_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } acc_t;

    rdy_t ifQ[$];
    rdy_t memQ[$];
    acc_t ramQ[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] romWord(input logic [31:0] a);
        case (a)
            32'h0040_0000: romWord = 32'h2108_000A;
            32'h0040_0004: romWord = 32'h00A0_0093;
            32'h0040_0008: romWord = 32'hAAAA_5555;
            32'h0040_0020: romWord = 32'h8C22_0004;
            32'h1001_0000: romWord = 32'h1234_5678;
            32'h1001_0008: romWord = 32'h0BAD_F00D;
            32'h1001_000C: romWord = 32'hCAFE_F00D;
            default:       romWord = 32'hFFFF_FFFF;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gDut
            localparam int LAT = (gi == 0) ? 2 : 1;
            logic [31:0] ifData, memRData, ramAddr, ramWData, ramRData;
            logic        ifReady, memReady, ramEn, ramWe, stallIF, stallPipe;
            logic [3:0]  enRun;

            unified_mem_arbiter #(
                .MEM_LATENCY(LAT),
                .ADDR_WIDTH (32),
                .DATA_WIDTH (32)
            ) dut (
                .clock      (clock),
                .resetN     (resetN),
                .ifReq      (ifReq),
                .ifAddr     (ifAddr),
                .flushIF    (flushIF),
                .ifData     (ifData),
                .ifReady    (ifReady),
                .memReadMEM (memReadMEM),
                .memWriteMEM(memWriteMEM),
                .memAddrMEM (memAddrMEM),
                .memWDataMEM(memWDataMEM),
                .memRData   (memRData),
                .memReady   (memReady),
                .ramEn      (ramEn),
                .ramWe      (ramWe),
                .ramAddr    (ramAddr),
                .ramWData   (ramWData),
                .ramRData   (ramRData),
                .stallIF    (stallIF),
                .stallPipe  (stallPipe)
            );

            // Memory model: read data is only valid in the last held cycle
            always @(posedge clock or negedge resetN) begin
                if (!resetN) enRun <= 4'd0;
                else         enRun <= ramEn ? enRun + 4'd1 : 4'd0;
            end
            assign ramRData = (ramEn && enRun == 4'(LAT - 1)) ? romWord(ramAddr) : 32'hBAD0_BAD0;
        end
    endgenerate

    logic [31:0] monIfData, monMemRData, monRamAddr, monRamWData;
    logic        monIfReady, monMemReady, monRamEn, monRamWe, monStallIF, monStallPipe;
    assign monIfData    = sel ? gDut[1].ifData    : gDut[0].ifData;
    assign monMemRData  = sel ? gDut[1].memRData  : gDut[0].memRData;
    assign monRamAddr   = sel ? gDut[1].ramAddr   : gDut[0].ramAddr;
    assign monRamWData  = sel ? gDut[1].ramWData  : gDut[0].ramWData;
    assign monIfReady   = sel ? gDut[1].ifReady   : gDut[0].ifReady;
    assign monMemReady  = sel ? gDut[1].memReady  : gDut[0].memReady;
    assign monRamEn     = sel ? gDut[1].ramEn     : gDut[0].ramEn;
    assign monRamWe     = sel ? gDut[1].ramWe     : gDut[0].ramWe;
    assign monStallIF   = sel ? gDut[1].stallIF   : gDut[0].stallIF;
    assign monStallPipe = sel ? gDut[1].stallPipe : gDut[0].stallPipe;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pushAcc(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input int start, input int lat);
        for (int k = 1; k <= lat; k++) begin
            acc_t e;
            e.we = we; e.addr = a; e.wdata = wd; e.cyc = start + k;
            ramQ.push_back(e);
        end
    endtask

    task automatic pushIf(input logic [31:0] d, input int c);
        rdy_t e;
        e.data = d; e.cyc = c;
        ifQ.push_back(e);
    endtask

    task automatic pushMem(input logic [31:0] d, input int c);
        rdy_t e;
        e.data = d; e.cyc = c;
        memQ.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a ready pulse or a port access
    always @(negedge clock) begin
        if (resetN) begin
            if (monIfReady) begin
                check("ifReady_expected", 64'(ifQ.size() != 0), 64'd1);
                if (ifQ.size() != 0) begin
                    rdy_t e;
                    e = ifQ.pop_front();
                    $display("ifReady  cyc=%0d data=%h", cyc, monIfData);
                    check("ifReady_cycle", 64'(cyc), 64'(e.cyc));
                    check("ifData", 64'(monIfData), 64'(e.data));
                end
            end
            if (monMemReady) begin
                check("memReady_expected", 64'(memQ.size() != 0), 64'd1);
                if (memQ.size() != 0) begin
                    rdy_t e;
                    e = memQ.pop_front();
                    $display("memReady cyc=%0d data=%h", cyc, monMemRData);
                    check("memReady_cycle", 64'(cyc), 64'(e.cyc));
                    check("memRData", 64'(monMemRData), 64'(e.data));
                end
            end
            if (monRamEn) begin
                check("ramEn_expected", 64'(ramQ.size() != 0), 64'd1);
                if (ramQ.size() != 0) begin
                    acc_t e;
                    e = ramQ.pop_front();
                    $display("ramAcc   cyc=%0d we=%b addr=%h wdata=%h", cyc, monRamWe, monRamAddr, monRamWData);
                    check("ramEn_cycle", 64'(cyc), 64'(e.cyc));
                    check("ramWe", 64'(monRamWe), 64'(e.we));
                    check("ramAddr", 64'(monRamAddr), 64'(e.addr));
                    if (e.we) check("ramWData", 64'(monRamWData), 64'(e.wdata));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        resetN = 1'b0; sel = 1'b0;
        ifReq = 1'b0; flushIF = 1'b0; memReadMEM = 1'b0; memWriteMEM = 1'b0;
        ifAddr = '0; memAddrMEM = '0; memWDataMEM = '0;

        // Reset values and combinational stalls
        step(); step();
        ifReq = 1'b1;
        #1;
        check("rst_ifReady", 64'(monIfReady), 64'd0);
        check("rst_memReady", 64'(monMemReady), 64'd0);
        check("rst_ramEn", 64'(monRamEn), 64'd0);
        check("rst_ramWe", 64'(monRamWe), 64'd0);
        check("rst_ifData", 64'(monIfData), 64'd0);
        check("rst_memRData", 64'(monMemRData), 64'd0);
        check("rst_ramAddr", 64'(monRamAddr), 64'd0);
        check("rst_ramWData", 64'(monRamWData), 64'd0);
        check("rst_stallIF", 64'(monStallIF), 64'd1);
        check("rst_stallPipe_lo", 64'(monStallPipe), 64'd0);
        memReadMEM = 1'b1;
        #1;
        check("rst_stallPipe_hi", 64'(monStallPipe), 64'd1);
        ifReq = 1'b0; memReadMEM = 1'b0;
        step();
        resetN = 1'b1;
        step();

        // Fetch, latency 2
        step(); t0 = cyc;
        ifReq = 1'b1; ifAddr = 32'h0040_0000;
        pushAcc(1'b0, 32'h0040_0000, 32'h0, t0, 2);
        pushIf(32'h2108_000A, t0 + 3);
        #1 check("fetch_stallIF_c0", 64'(monStallIF), 64'd1);
        step(); check("fetch_stallIF_c1", 64'(monStallIF), 64'd1);
        step(); check("fetch_stallIF_c2", 64'(monStallIF), 64'd1);
        step(); check("fetch_stallIF_c3", 64'(monStallIF), 64'd0);
        ifReq = 1'b0;

        // Contention: MEM first, IF sampled in the MEM ready cycle
        step(); t0 = cyc;
        ifReq = 1'b1; ifAddr = 32'h0040_0004;
        memReadMEM = 1'b1; memAddrMEM = 32'h1001_0000;
        pushAcc(1'b0, 32'h1001_0000, 32'h0, t0, 2);
        pushMem(32'h1234_5678, t0 + 3);
        pushAcc(1'b0, 32'h0040_0004, 32'h0, t0 + 3, 2);
        pushIf(32'h00A0_0093, t0 + 6);
        #1 check("cont_stallPipe_c0", 64'(monStallPipe), 64'd1);
        repeat (3) step();
        check("cont_stallPipe_c3", 64'(monStallPipe), 64'd0);
        check("cont_stallIF_c3", 64'(monStallIF), 64'd1);
        memReadMEM = 1'b0;
        repeat (3) step();
        ifReq = 1'b0;

        // Store: memRData must keep the previous load value
        step(); t0 = cyc;
        memWriteMEM = 1'b1; memAddrMEM = 32'h1001_0004; memWDataMEM = 32'hDEAD_BEEF;
        pushAcc(1'b1, 32'h1001_0004, 32'hDEAD_BEEF, t0, 2);
        pushMem(32'h1234_5678, t0 + 3);
        repeat (3) step();
        memWriteMEM = 1'b0;

        // Read and write together: the store wins
        step(); t0 = cyc;
        memReadMEM = 1'b1; memWriteMEM = 1'b1;
        memAddrMEM = 32'h1001_0010; memWDataMEM = 32'h0123_4567;
        pushAcc(1'b1, 32'h1001_0010, 32'h0123_4567, t0, 2);
        pushMem(32'h1234_5678, t0 + 3);
        repeat (3) step();
        memReadMEM = 1'b0; memWriteMEM = 1'b0;

        // Flush in the completion cycle, then redirected fetch
        step(); t0 = cyc;
        ifReq = 1'b1; ifAddr = 32'h0040_0008;
        pushAcc(1'b0, 32'h0040_0008, 32'h0, t0, 2);
        step(); step();
        flushIF = 1'b1;
        step();
        flushIF = 1'b0;
        check("flush_noReady", 64'(monIfReady), 64'd0);
        check("flush_ifDataHeld", 64'(monIfData), 64'h00A0_0093);
        ifAddr = 32'h0040_0020;
        pushAcc(1'b0, 32'h0040_0020, 32'h0, t0 + 3, 2);
        pushIf(32'h8C22_0004, t0 + 6);
        repeat (3) step();
        ifReq = 1'b0;

        // Asynchronous reset in the middle of a load
        step();
        memReadMEM = 1'b1; memAddrMEM = 32'h1001_0000;
        step();
        check("midrst_ramEn_before", 64'(monRamEn), 64'd1);
        #2 resetN = 1'b0;
        #1;
        check("midrst_ramEn", 64'(monRamEn), 64'd0);
        check("midrst_ramWe", 64'(monRamWe), 64'd0);
        check("midrst_memReady", 64'(monMemReady), 64'd0);
        check("midrst_ifReady", 64'(monIfReady), 64'd0);
        check("midrst_memRData", 64'(monMemRData), 64'd0);
        memReadMEM = 1'b0;
        step(); step();
        resetN = 1'b1;
        step(); t0 = cyc;
        ifReq = 1'b1; ifAddr = 32'h0040_0000;
        pushAcc(1'b0, 32'h0040_0000, 32'h0, t0, 2);
        pushIf(32'h2108_000A, t0 + 3);
        repeat (3) step();
        ifReq = 1'b0;
        repeat (4) step();

        // Latency 1: back-to-back loads, one access every other cycle
        sel = 1'b1;
        step(); t0 = cyc;
        memReadMEM = 1'b1; memAddrMEM = 32'h1001_0008;
        pushAcc(1'b0, 32'h1001_0008, 32'h0, t0, 1);
        pushMem(32'h0BAD_F00D, t0 + 2);
        step(); step();
        memAddrMEM = 32'h1001_000C;
        pushAcc(1'b0, 32'h1001_000C, 32'h0, t0 + 2, 1);
        pushMem(32'hCAFE_F00D, t0 + 4);
        step(); step();
        memAddrMEM = 32'h1001_0000;
        pushAcc(1'b0, 32'h1001_0000, 32'h0, t0 + 4, 1);
        pushMem(32'h1234_5678, t0 + 6);
        step(); step();
        memReadMEM = 1'b0;
        repeat (4) step();

        check("ifQ_drained", 64'(ifQ.size()), 64'd0);
        check("memQ_drained", 64'(memQ.size()), 64'd0);
        check("ramQ_drained", 64'(ramQ.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
